prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
Byte-stream bootloader controller for the 1024x18 program memory. It accepts framed program images on a byte valid/ready interface and sequences 18-bit writes into the write port of the RAM-backed program memory. It holds the MCU in reset while loading and after any failed load, so the processor never fetches a partially written image. It sits between the serial receiver and the program memory write port; the CPU fetch path is untouched.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame (10 ms at 100 MHz)
HOLD_CYCLES, 16, cycles CPU_HOLD stays asserted after a successful load

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
RX_DATA  in  8  incoming byte
RX_VALID  in  1  RX_DATA valid
RX_READY  out  1  byte accepted when RX_VALID & RX_READY at the clock edge
MEM_WE  out  1  program memory write enable, one-cycle pulse
MEM_ADDR  out  10  program memory write address
MEM_WDATA  out  18  program memory write data
CPU_HOLD  out  1  high holds MCU in reset
BUSY  out  1  high whenever state is not IDLE
LOAD_DONE  out  1  one-cycle pulse on successful frame
LOAD_ERR  out  1  sticky error flag

Behaviour:
- Frame format: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then N x (B0, B1, B2), then CHK. N = {CNT_HI[1:0], CNT_LO} + 1, range 1..1024. Start address = {ADDR_HI[1:0], ADDR_LO}. Word = {B0[1:0], B1, B2}.
- CHK must equal the mod-256 sum of every byte after SYNC and before CHK.
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, B0, B1, B2, WRITE, CHK, HOLD. Each byte-consuming state advances only on an accepted byte.
- IDLE: RX_READY=1. Non-SYNC bytes are discarded. On SYNC, go to ADDR_HI. On that same edge: CPU_HOLD<=1, LOAD_ERR<=0, checksum<=0.
- Range checks: ADDR_HI, CNT_HI and B0 must have bits [7:2] = 0. Any nonzero bit there is an error.
- B2 accepted: next cycle is WRITE. In WRITE, MEM_WE=1 with MEM_ADDR and MEM_WDATA valid for exactly one cycle, and RX_READY=0.
- After WRITE: address increments mod 1024, so 0x3FF wraps to 0x000. Remaining count decrements. If this was the last word, go to CHK; otherwise go to B0.
- CHK, byte matches: go to HOLD and pulse LOAD_DONE for one cycle.
- CHK, byte mismatches: error.
- HOLD: RX_READY=0. Count HOLD_CYCLES cycles, then deassert CPU_HOLD and go to IDLE.
- Error (range check, checksum, or timeout): LOAD_ERR<=1, go to IDLE. CPU_HOLD stays 1 until a later successful frame finishes its HOLD.
- Timeout: counter clears on every accepted byte and is active only in ADDR_HI..B2 and CHK. Error when the counter reaches TIMEOUT_CYCLES-1.
- MEM_WE is 0 in every state except WRITE. MEM_ADDR and MEM_WDATA are don't-care outside WRITE but registered (no combinational path from RX_DATA).
- Reset (any time, including mid-frame): state=IDLE, RX_READY=1, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, CPU_HOLD=0, BUSY=0, LOAD_DONE=0, LOAD_ERR=0. Words already written stay written.
- All outputs are registered.

Decomposition:
- Shared package: state enum, SYNC default, frame byte-count constants, PMEM_ADDR_W=10, PMEM_DATA_W=18.
- One natural sub-module: prog_mem_loader_timeout, a loadable down-counter with clear and expire.
- Checksum accumulator and word assembly stay inline.

Test Plan:
- Reset: assert RST_N=0 mid-frame -> all outputs take reset values, RX_READY=1, no MEM_WE.
- Single word: send A5 00 05 00 00 01 23 45 6E -> exactly one MEM_WE with addr 0x005, data 0x12345. LOAD_DONE pulses. CPU_HOLD falls 16 cycles later. LOAD_ERR=0.
- Wrap: send A5 03 FF 00 01 + two words 00 00 AA and 03 FF FF + correct CHK -> writes 0x3FF=0x000AA, then 0x000=0x3FFFF. RX_READY=0 during each WRITE cycle.
- Bad checksum: single-word frame with CHK=6F -> one write, then LOAD_ERR=1 and CPU_HOLD stays 1. A following good frame clears LOAD_ERR and releases CPU_HOLD.
- Timeout (TIMEOUT_CYCLES=100): stop after B1 -> LOAD_ERR=1 after 100 idle cycles, state IDLE, no MEM_WE.
- Garbage and range: bytes 00 FF 5A in IDLE -> ignored, BUSY=0. Frame with ADDR_HI=04 -> LOAD_ERR=1, no writes.

Source files
------------

// File: rtl/prog_mem_loader_pkg.sv
// prog_mem_loader_pkg: shared types and constants for the program memory bootloader
package prog_mem_loader_pkg;
  localparam int PMEM_ADDR_W = 10;
  localparam int PMEM_DATA_W = 18;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
    S_B0, S_B1, S_B2, S_WRITE, S_CHK, S_HOLD
  } state_e;
  function automatic logic hi_ok(input logic [7:0] b);
    return b[7:2] == 6'd0;
  endfunction
endpackage

// File: rtl/prog_mem_loader_timeout.sv
// prog_mem_loader_timeout: loadable down-counter flagging too many idle cycles between bytes
module prog_mem_loader_timeout #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  // reload on every accepted byte or when idle, otherwise count down to zero
  always_comb begin
    cnt_d = load ? W'(CYCLES - 1) : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  end
  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= W'(CYCLES - 1);
    else        cnt_q <= cnt_d;
  end
  assign expired = en && !load && cnt_q == '0;
endmodule

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: framed byte-stream bootloader writing 18-bit words into program memory
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES    = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [7:0]             RX_DATA,
  input  logic                   RX_VALID,
  output logic                   RX_READY,
  output logic                   MEM_WE,
  output logic [PMEM_ADDR_W-1:0] MEM_ADDR,
  output logic [PMEM_DATA_W-1:0] MEM_WDATA,
  output logic                   CPU_HOLD,
  output logic                   BUSY,
  output logic                   LOAD_DONE,
  output logic                   LOAD_ERR
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  state_e                 state_q, state_d;
  logic [PMEM_ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d, mem_addr_q, mem_addr_d;
  logic [PMEM_DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]             csum_q, csum_d, b1_q, b1_d;
  logic [1:0]             b0_q, b0_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic rx_ready_q, rx_ready_d, mem_we_q, mem_we_d, cpu_hold_q, cpu_hold_d;
  logic busy_q, busy_d, load_done_q, load_done_d, load_err_q, load_err_d;
  logic acc, active, tmo, err;
  assign acc    = RX_VALID && rx_ready_q;
  assign active = state_q inside {S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO, S_B0, S_B1, S_B2, S_CHK};
  prog_mem_loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(CLK), .rst_n(RST_N), .load(acc || !active), .en(active), .expired(tmo)
  );
  // frame parser: header capture, word assembly, checksum, write sequencing and hold-off
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    hold_d      = hold_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    load_err_d  = load_err_q;
    load_done_d = 1'b0;
    err         = 1'b0;
    if (acc && state_q inside {S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO, S_B0, S_B1, S_B2})
      csum_d = csum_q + RX_DATA;
    unique case (state_q)
      S_IDLE: if (acc && RX_DATA == SYNC_BYTE) begin
        state_d    = S_ADDR_HI;
        cpu_hold_d = 1'b1;
        load_err_d = 1'b0;
        csum_d     = 8'd0;
      end
      S_ADDR_HI: if (acc) begin
        err         = !hi_ok(RX_DATA);
        addr_d[9:8] = RX_DATA[1:0];
        state_d     = S_ADDR_LO;
      end
      S_ADDR_LO: if (acc) begin
        addr_d[7:0] = RX_DATA;
        state_d     = S_CNT_HI;
      end
      S_CNT_HI: if (acc) begin
        err        = !hi_ok(RX_DATA);
        cnt_d[9:8] = RX_DATA[1:0];
        state_d    = S_CNT_LO;
      end
      S_CNT_LO: if (acc) begin
        cnt_d[7:0] = RX_DATA;
        state_d    = S_B0;
      end
      S_B0: if (acc) begin
        err     = !hi_ok(RX_DATA);
        b0_d    = RX_DATA[1:0];
        state_d = S_B1;
      end
      S_B1: if (acc) begin
        b1_d    = RX_DATA;
        state_d = S_B2;
      end
      S_B2: if (acc) begin
        mem_addr_d  = addr_q;
        mem_wdata_d = {b0_q, b1_q, RX_DATA};
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        addr_d  = addr_q + 10'd1;
        cnt_d   = cnt_q - 10'd1;
        state_d = (cnt_q == '0) ? S_CHK : S_B0;
      end
      S_CHK: if (acc) begin
        err         = RX_DATA != csum_q;
        load_done_d = RX_DATA == csum_q;
        hold_d      = HW'(HOLD_CYCLES - 1);
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        hold_d     = hold_q - HW'(1);
        cpu_hold_d = hold_q != '0;
        state_d    = (hold_q == '0) ? S_IDLE : S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
    if (err || tmo) begin
      state_d    = S_IDLE;
      load_err_d = 1'b1;
    end
    mem_we_d   = state_d == S_WRITE;
    rx_ready_d = !(state_d inside {S_WRITE, S_HOLD});
    busy_d     = state_d != S_IDLE;
  end
  // all state and outputs registered; reset leaves memory contents alone
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      hold_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rx_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      hold_q      <= hold_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end
  assign RX_READY  = rx_ready_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign CPU_HOLD  = cpu_hold_q;
  assign BUSY      = busy_q;
  assign LOAD_DONE = load_done_q;
  assign LOAD_ERR  = load_err_q;
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed frame vectors plus reset, timeout and hold-timing sequences
module tb_prog_mem_loader;
  logic        CLK, RST_N, RX_VALID;
  logic [7:0]  RX_DATA;
  logic        RX_READY, MEM_WE, CPU_HOLD, BUSY, LOAD_DONE, LOAD_ERR;
  logic [9:0]  MEM_ADDR;
  logic [17:0] MEM_WDATA;
  int total, bad, done_cnt, we_rdy_bad;
  logic [9:0]  wa[$];
  logic [17:0] wd[$];

  typedef struct {
    int              len;
    logic [0:11][7:0] b;
    int              nw;
    logic [9:0]      a0;
    logic [17:0]     d0;
    logic [9:0]      a1;
    logic [17:0]     d1;
    logic            err;
    logic            done;
    logic            hold;
  } vec_t;
  vec_t v[9];

  prog_mem_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100), .HOLD_CYCLES(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .CPU_HOLD(CPU_HOLD),
    .BUSY(BUSY), .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // log every write and done pulse on the falling edge
  always @(negedge CLK) begin
    if (MEM_WE) begin
      wa.push_back(MEM_ADDR);
      wd.push_back(MEM_WDATA);
      if (RX_READY) we_rdy_bad++;
    end
    if (LOAD_DONE) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    n = 0;
    while (!RX_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL rx_ready_wait: ready=0 required=1");
    end
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  initial begin
    int w0, d0c, n;
    total = 0; bad = 0; done_cnt = 0; we_rdy_bad = 0;
    v[0] = '{9,  {8'hA5,8'h00,8'h05,8'h00,8'h00,8'h01,8'h23,8'h45,8'h6E,24'h0}, 1, 10'h005, 18'h12345, 10'h0, 18'h0, 1'b0, 1'b1, 1'b0};
    v[1] = '{12, {8'hA5,8'h03,8'hFF,8'h00,8'h01,8'h00,8'h00,8'hAA,8'h03,8'hFF,8'hFF,8'hAE}, 2, 10'h3FF, 18'h000AA, 10'h000, 18'h3FFFF, 1'b0, 1'b1, 1'b0};
    v[2] = '{9,  {8'hA5,8'h00,8'h05,8'h00,8'h00,8'h01,8'h23,8'h45,8'h6F,24'h0}, 1, 10'h005, 18'h12345, 10'h0, 18'h0, 1'b1, 1'b0, 1'b1};
    v[3] = '{9,  {8'hA5,8'h00,8'h05,8'h00,8'h00,8'h01,8'h23,8'h45,8'h6E,24'h0}, 1, 10'h005, 18'h12345, 10'h0, 18'h0, 1'b0, 1'b1, 1'b0};
    v[4] = '{3,  {8'h00,8'hFF,8'h5A,72'h0}, 0, 10'h0, 18'h0, 10'h0, 18'h0, 1'b0, 1'b0, 1'b0};
    v[5] = '{2,  {8'hA5,8'h04,80'h0}, 0, 10'h0, 18'h0, 10'h0, 18'h0, 1'b1, 1'b0, 1'b1};
    v[6] = '{4,  {8'hA5,8'h00,8'h00,8'h04,64'h0}, 0, 10'h0, 18'h0, 10'h0, 18'h0, 1'b1, 1'b0, 1'b1};
    v[7] = '{6,  {8'hA5,8'h00,8'h10,8'h00,8'h00,8'h04,48'h0}, 0, 10'h0, 18'h0, 10'h0, 18'h0, 1'b1, 1'b0, 1'b1};
    v[8] = '{9,  {8'hA5,8'h02,8'hAB,8'h00,8'h00,8'h02,8'h34,8'h56,8'h39,24'h0}, 1, 10'h2AB, 18'h23456, 10'h0, 18'h0, 1'b0, 1'b1, 1'b0};
    RST_N = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst rx_ready", RX_READY, 1);
    chk("rst mem_we", MEM_WE, 0);
    chk("rst mem_addr", MEM_ADDR, 0);
    chk("rst mem_wdata", MEM_WDATA, 0);
    chk("rst cpu_hold", CPU_HOLD, 0);
    chk("rst busy", BUSY, 0);
    chk("rst load_done", LOAD_DONE, 0);
    chk("rst load_err", LOAD_ERR, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 9; i++) begin
      w0 = wa.size();
      d0c = done_cnt;
      for (int j = 0; j < v[i].len; j++) send_byte(v[i].b[j]);
      n = 0;
      while (BUSY && n < 200) begin
        @(negedge CLK);
        n++;
      end
      @(negedge CLK);
      #1;
      chk($sformatf("v%0d busy", i), BUSY, 0);
      chk($sformatf("v%0d nwrites", i), wa.size() - w0, v[i].nw);
      if (v[i].nw >= 1 && wa.size() > w0) begin
        chk($sformatf("v%0d addr0", i), wa[w0], v[i].a0);
        chk($sformatf("v%0d data0", i), wd[w0], v[i].d0);
      end
      if (v[i].nw >= 2 && wa.size() > w0 + 1) begin
        chk($sformatf("v%0d addr1", i), wa[w0+1], v[i].a1);
        chk($sformatf("v%0d data1", i), wd[w0+1], v[i].d1);
      end
      chk($sformatf("v%0d load_err", i), LOAD_ERR, v[i].err);
      chk($sformatf("v%0d done", i), done_cnt - d0c, v[i].done ? 1 : 0);
      chk($sformatf("v%0d cpu_hold", i), CPU_HOLD, v[i].hold);
    end
    // timeout: stop after B1, error lands exactly 100 cycles after the last byte
    w0 = wa.size();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h23);
    repeat (99) @(negedge CLK);
    chk("tmo err early", LOAD_ERR, 0);
    chk("tmo busy early", BUSY, 1);
    @(negedge CLK);
    chk("tmo err", LOAD_ERR, 1);
    chk("tmo busy", BUSY, 0);
    chk("tmo hold", CPU_HOLD, 1);
    chk("tmo nwrites", wa.size() - w0, 0);
    // hold timing: CPU_HOLD falls 16 cycles after LOAD_DONE
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
    send_byte(8'h6E);
    chk("hold done", LOAD_DONE, 1);
    chk("hold err", LOAD_ERR, 0);
    chk("hold rx_ready", RX_READY, 0);
    @(negedge CLK);
    chk("hold done width", LOAD_DONE, 0);
    n = 1;
    while (CPU_HOLD && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("hold cycles", n, 16);
    chk("hold busy after", BUSY, 0);
    // reset in the middle of a frame
    w0 = wa.size();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h01);
    chk("mid busy", BUSY, 1);
    chk("mid hold", CPU_HOLD, 1);
    RST_N = 1'b0;
    #1;
    chk("mid rst rx_ready", RX_READY, 1);
    chk("mid rst busy", BUSY, 0);
    chk("mid rst cpu_hold", CPU_HOLD, 0);
    chk("mid rst mem_we", MEM_WE, 0);
    chk("mid rst load_err", LOAD_ERR, 0);
    chk("mid rst mem_addr", MEM_ADDR, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("mid rst nwrites", wa.size() - w0, 0);
    chk("ready during write", we_rdy_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
